// File: rtl/pipelined_dual_logic_unit.sv
// Dual bitwise logic unit: two opcode-selected results per transaction,
// carried through a STAGES-deep valid/ready pipeline with per-stage stall.
module pipelined_dual_logic_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_c,
  input  logic [2:0]       op_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d
);

  localparam int unsigned IW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0][WIDTH-1:0] r_c;
  logic [STAGES-1:0][WIDTH-1:0] r_d;
  logic [STAGES-1:0]            w_load;
  logic                         w_open;
  logic [WIDTH-1:0]             w_c;
  logic [WIDTH-1:0]             w_d;

  function automatic logic [WIDTH-1:0] f_logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return x ^ y;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return ~(x ^ y);
      3'd6:    return x & ~y;
      default: return x;
    endcase
  endfunction

  assign w_c = f_logic_op(op_c, a, b);
  assign w_d = f_logic_op(op_d, a, b);

  // Stage i loads when out_ready is high or any stage from i to the output
  // is empty; this is the unrolled form of load[i] = !valid[i] || load[i+1].
  always_comb begin
    w_load = '0;
    w_open = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_open                      = w_open | ~r_valid[IW'(STAGES - 1 - k)];
      w_load[IW'(STAGES - 1 - k)] = w_open;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_c[0] <= w_c;
          r_d[0] <= w_d;
        end
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (w_load[IW'(i)]) begin
          r_valid[IW'(i)] <= r_valid[IW'(i - 1)];
          if (r_valid[IW'(i - 1)]) begin
            r_c[IW'(i)] <= r_c[IW'(i - 1)];
            r_d[IW'(i)] <= r_d[IW'(i - 1)];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[IW'(STAGES - 1)];
  assign c         = r_c[IW'(STAGES - 1)];
  assign d         = r_d[IW'(STAGES - 1)];

endmodule

// File: tb/tb_pipelined_dual_logic_unit.sv
// Bench for pipelined_dual_logic_unit: directed vector table, stall/fill,
// async reset and randomized handshake sequences against a reference queue.
module tb_pipelined_dual_logic_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=2, STAGES=1
  logic       s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [1:0] s1_a, s1_b, s1_c, s1_d;
  logic [2:0] s1_op_c, s1_op_d;
  // WIDTH=8, STAGES=3
  logic       s3_in_valid, s3_in_ready, s3_out_valid, s3_out_ready;
  logic [7:0] s3_a, s3_b, s3_c, s3_d;
  logic [2:0] s3_op_c, s3_op_d;
  // WIDTH=8, STAGES=2 (scoreboarded)
  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [7:0] m_a, m_b, m_c, m_d;
  logic [2:0] m_op_c, m_op_d;

  pipelined_dual_logic_unit #(.WIDTH(2), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .op_c(s1_op_c), .op_d(s1_op_d),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .c(s1_c), .d(s1_d));

  pipelined_dual_logic_unit #(.WIDTH(8), .STAGES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
    .a(s3_a), .b(s3_b), .op_c(s3_op_c), .op_d(s3_op_d),
    .out_valid(s3_out_valid), .out_ready(s3_out_ready), .c(s3_c), .d(s3_d));

  pipelined_dual_logic_unit #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .op_c(m_op_c), .op_d(m_op_d),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .c(m_c), .d(m_d));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] opc;
    logic [2:0] opd;
    logic [7:0] ec;
    logic [7:0] ed;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [7:0]  obs_c[$];
  logic [7:0]  obs_d[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] mdl(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    r = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      case (op)
        3'd0: r[i] = x[i] && y[i];
        3'd1: r[i] = x[i] || y[i];
        3'd2: r[i] = x[i] != y[i];
        3'd3: r[i] = !(x[i] && y[i]);
        3'd4: r[i] = !(x[i] || y[i]);
        3'd5: r[i] = x[i] == y[i];
        3'd6: r[i] = x[i] && !y[i];
        3'd7: r[i] = x[i];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Scoreboard for u_dut; handshakes sampled mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (m_out_valid && m_out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got output c=0x%0h d=0x%0h, expected none", m_c, m_d);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("sb_c", 32'(m_c), 32'(e[15:8]));
          chk("sb_d", 32'(m_d), 32'(e[7:0]));
        end
        obs_c.push_back(m_c);
        obs_d.push_back(m_d);
      end
      if (m_in_valid && m_in_ready)
        exp_q.push_back({mdl(m_op_c, m_a, m_b), mdl(m_op_d, m_a, m_b)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int cyc;
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    int   k;
    int   cyc;
    logic acc;

    vt[0] = '{8'hF0, 8'h3C, 3'd2, 3'd6, 8'hCC, 8'hC0};
    vt[1] = '{8'hF0, 8'h3C, 3'd3, 3'd7, 8'hCF, 8'hF0};
    vt[2] = '{8'hF0, 8'h3C, 3'd0, 3'd1, 8'h30, 8'hFC};
    vt[3] = '{8'hF0, 8'h3C, 3'd4, 3'd5, 8'h03, 8'h33};
    vt[4] = '{8'hAA, 8'h0F, 3'd5, 3'd0, 8'h5A, 8'h0A};
    vt[5] = '{8'hAA, 8'h0F, 3'd6, 3'd4, 8'hA0, 8'h50};
    vt[6] = '{8'h00, 8'hFF, 3'd7, 3'd3, 8'h00, 8'hFF};

    s1_in_valid = 0; s1_a = '0; s1_b = '0; s1_op_c = 3'd0; s1_op_d = 3'd1; s1_out_ready = 1;
    s3_in_valid = 0; s3_a = '0; s3_b = '0; s3_op_c = 3'd0; s3_op_d = 3'd0; s3_out_ready = 1;
    m_in_valid = 0;  m_a = '0;  m_b = '0;  m_op_c = 3'd0;  m_op_d = 3'd0;  m_out_ready = 1;

    repeat (3) step();
    chk("rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("rst_c", 32'(m_c), 32'd0);
    chk("rst_d", 32'(m_d), 32'd0);
    chk("rst_in_ready", 32'(m_in_ready), 32'd1);
    chk("rst_s3_out_valid", 32'(s3_out_valid), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(m_in_ready), 32'd1);
    mon_en = 1'b1;

    // STAGES=1 sweep: AND / OR, one edge of latency, full throughput
    for (int i = 0; i < 16; i++) begin
      logic [1:0] ta, tb;
      ta = 2'(i >> 2);
      tb = 2'(i);
      s1_a = ta; s1_b = tb; s1_in_valid = 1'b1;
      #1 chk("s1_in_ready", 32'(s1_in_ready), 32'd1);
      step();
      chk("s1_out_valid", 32'(s1_out_valid), 32'd1);
      chk("s1_c", 32'(s1_c), 32'(ta & tb));
      chk("s1_d", 32'(s1_d), 32'(ta | tb));
    end
    s1_in_valid = 1'b0;
    step();
    chk("s1_drained", 32'(s1_out_valid), 32'd0);

    // STAGES=3 vector table: latency boundary and every opcode
    foreach (vt[i]) begin
      s3_a = vt[i].a; s3_b = vt[i].b; s3_op_c = vt[i].opc; s3_op_d = vt[i].opd;
      s3_in_valid = 1'b1;
      step();
      s3_in_valid = 1'b0;
      chk("s3_lat1", 32'(s3_out_valid), 32'd0);
      step();
      chk("s3_lat2", 32'(s3_out_valid), 32'd0);
      step();
      chk("s3_lat3_valid", 32'(s3_out_valid), 32'd1);
      chk("s3_c", 32'(s3_c), 32'(vt[i].ec));
      chk("s3_d", 32'(s3_d), 32'(vt[i].ed));
      step();
      chk("s3_after", 32'(s3_out_valid), 32'd0);
    end

    // Stall: out_ready low, only 2 transactions fit
    obs_c.delete(); obs_d.delete();
    m_out_ready = 1'b0;
    m_b = 8'hFF; m_op_c = 3'd0; m_op_d = 3'd4;
    k = 1;
    for (cyc = 0; cyc < 4; cyc++) begin
      m_a = 8'(k); m_in_valid = 1'b1;
      @(negedge clk);
      acc = m_in_ready;
      step();
      if (acc) k++;
    end
    chk("stall_accepted", 32'(k - 1), 32'd2);
    chk("stall_in_ready", 32'(m_in_ready), 32'd0);
    chk("stall_out_valid", 32'(m_out_valid), 32'd1);
    chk("stall_head_c", 32'(m_c), 32'd1);
    m_out_ready = 1'b1;
    while (k <= 5 && cyc < 30) begin
      m_a = 8'(k); m_in_valid = 1'b1;
      @(negedge clk);
      acc = m_in_ready;
      step();
      if (acc) k++;
      cyc++;
    end
    drain("stall_drain");
    chk("stall_count", 32'(obs_c.size()), 32'd5);
    foreach (obs_c[i]) begin
      chk("stall_seq_c", 32'(obs_c[i]), 32'(i + 1));
      chk("stall_seq_d", 32'(obs_d[i]), 32'd0);
    end

    // Back-to-back with full pipe: accept and retire every cycle
    m_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      m_a = 8'(i * 17); m_b = 8'(8'hA5 ^ i); m_op_c = 3'(i); m_op_d = 3'(7 - i);
      m_in_valid = 1'b1;
      step();
      if (i >= 1) begin
        chk("b2b_in_ready", 32'(m_in_ready), 32'd1);
        chk("b2b_out_valid", 32'(m_out_valid), 32'd1);
      end
    end
    drain("b2b_drain");

    // Async reset with two transactions in flight
    m_out_ready = 1'b0;
    m_a = 8'h55; m_b = 8'h0A; m_op_c = 3'd1; m_op_d = 3'd7;
    m_in_valid = 1'b1;
    step();
    step();
    m_in_valid = 1'b0;
    step();
    chk("pre_rst_valid", 32'(m_out_valid), 32'd1);
    chk("pre_rst_c", 32'(m_c), 32'h5F);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(m_out_valid), 32'd0);
    chk("arst_c", 32'(m_c), 32'd0);
    chk("arst_d", 32'(m_d), 32'd0);
    chk("arst_in_ready", 32'(m_in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    m_out_ready = 1'b1;
    step();
    chk("rel_in_ready", 32'(m_in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("rel_no_stale", 32'(m_out_valid), 32'd0);
      step();
    end

    // Random handshake traffic against the reference queue
    for (int i = 0; i < 1000; i++) begin
      m_in_valid  = 1'($urandom_range(0, 1));
      m_out_ready = 1'($urandom_range(0, 1));
      m_a    = 8'($urandom);
      m_b    = 8'($urandom);
      m_op_c = 3'($urandom_range(0, 7));
      m_op_d = 3'($urandom_range(0, 7));
      step();
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
